opal_com_tx: RTL and testbench

//  Transmit side of the OPAL-RT digital-I/O link: sends QTD_VARIABLES words of

---
 rtl/opal_com_tx.sv | 165 ++++++++++++++++
 tb/tb_opal_com_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/opal_com_tx.sv
// opal_com_tx: transmit side of the OPAL-RT digital-I/O link.
// Shifts one word per lane MSB first behind a generated serial clock and frame enable.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high
//   i_data   flat words, lane k = i_data[k*OPAL_OUTPUT_WIDTH +: OPAL_OUTPUT_WIDTH]
//   i_valid  request to send i_data (accepted only while idle)
//   o_ready  idle, a frame can be accepted
//   o_data   {serial clk, enable, lanes[QTD_VARIABLES-1:0]}
//   o_busy   frame in progress (shift or gap)
//   o_done   one-cycle pulse when a frame completes
module opal_com_tx #(
    parameter int QTD_VARIABLES     = 16,
    parameter int OPAL_OUTPUT_WIDTH = 16,
    parameter int CLK_DIV           = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [QTD_VARIABLES*OPAL_OUTPUT_WIDTH-1:0] i_data,
    input  logic                                       i_valid,
    output logic                                       o_ready,
    output logic [QTD_VARIABLES+1:0]                   o_data,
    output logic                                       o_busy,
    output logic                                       o_done
);

    localparam int N  = QTD_VARIABLES;
    localparam int W  = OPAL_OUTPUT_WIDTH;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (W > 1) ? $clog2(W) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [DW-1:0]  r_div;
    logic [DW-1:0]  w_div_nx;
    logic           r_phase;
    logic           w_phase_nx;
    logic [BW-1:0]  r_bit;
    logic [BW-1:0]  w_bit_nx;
    logic [W-1:0]   r_sh [N];
    logic [W-1:0]   w_sh_nx [N];
    logic [N+1:0]   r_data;
    logic [N+1:0]   w_data_nx;
    logic           r_ready;
    logic           r_busy;
    logic           r_done;
    logic           w_done_nx;
    logic           w_half_end;
    logic           w_en_nx;
    logic [N-1:0]   w_msb;

    assign o_data  = r_data;
    assign o_ready = r_ready;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_data  <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_sh[k] <= '0;
            end
        end else begin
            r_state <= w_state_nx;
            r_div   <= w_div_nx;
            r_phase <= w_phase_nx;
            r_bit   <= w_bit_nx;
            r_data  <= w_data_nx;
            r_ready <= (w_state_nx == S_IDLE);
            r_busy  <= (w_state_nx != S_IDLE);
            r_done  <= w_done_nx;
            for (int k = 0; k < N; k++) begin
                r_sh[k] <= w_sh_nx[k];
            end
        end
    end

    // Each serial bit (and the gap) is two half periods: phase 0 = serial
    // clock low, phase 1 = high. The divider only advances outside IDLE.
    always_comb begin
        w_state_nx = r_state;
        w_div_nx   = r_div;
        w_phase_nx = r_phase;
        w_bit_nx   = r_bit;
        w_done_nx  = 1'b0;
        w_half_end = (r_div == DIV_LAST);
        for (int k = 0; k < N; k++) begin
            w_sh_nx[k] = r_sh[k];
        end

        unique case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_state_nx = S_SHIFT;
                    w_div_nx   = '0;
                    w_phase_nx = 1'b0;
                    w_bit_nx   = '0;
                    for (int k = 0; k < N; k++) begin
                        w_sh_nx[k] = i_data[k*W +: W];
                    end
                end
            end
            S_SHIFT: begin
                if (w_half_end) begin
                    w_div_nx   = '0;
                    w_phase_nx = ~r_phase;
                    if (r_phase) begin
                        if (r_bit == BIT_LAST) begin
                            w_state_nx = S_GAP;
                            w_bit_nx   = '0;
                        end else begin
                            w_bit_nx = r_bit + 1'b1;
                            for (int k = 0; k < N; k++) begin
                                w_sh_nx[k] = r_sh[k] << 1;
                            end
                        end
                    end
                end else begin
                    w_div_nx = r_div + 1'b1;
                end
            end
            S_GAP: begin
                if (w_half_end) begin
                    w_div_nx   = '0;
                    w_phase_nx = ~r_phase;
                    if (r_phase) begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end
                end else begin
                    w_div_nx = r_div + 1'b1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Outputs are computed from the next state so they are registered
        // and line up with the state they describe.
        w_en_nx = (w_state_nx == S_SHIFT);
        for (int k = 0; k < N; k++) begin
            w_msb[k] = w_sh_nx[k][W-1];
        end
        w_data_nx = {w_en_nx & w_phase_nx, w_en_nx, w_en_nx ? w_msb : {N{1'b0}}};
    end

endmodule

// File: tb/tb_opal_com_tx.sv
// tb_opal_com_tx: directed bench for opal_com_tx.
// Main DUT at CLK_DIV=2, second DUT at CLK_DIV=1 for a receiver loopback.
module tb_opal_com_tx;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] i_data = '0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [17:0]  o_data;
    logic         o_busy;
    logic         o_done;

    logic [255:0] d1 = '0;
    logic         v1 = 1'b0;
    logic         r1;
    logic [17:0]  q1;
    logic         b1;
    logic         n1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    opal_com_tx #(.QTD_VARIABLES(16), .OPAL_OUTPUT_WIDTH(16), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_data(o_data), .o_busy(o_busy), .o_done(o_done)
    );

    opal_com_tx #(.QTD_VARIABLES(16), .OPAL_OUTPUT_WIDTH(16), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .i_data(d1), .i_valid(v1),
        .o_ready(r1), .o_data(q1), .o_busy(b1), .o_done(n1)
    );

    // Receiver for dut: samples lanes on serial-clock rising edges while enabled.
    logic [15:0] m0_sh [16];
    logic [15:0] m0_w [16];
    int m0_bits = 0, m0_lbits = 0, m0_frames = 0;
    int m0_en = 0, m0_len = 0, m0_low = 0, m0_gap = 0;
    logic m0_pc = 1'b0, m0_pe = 1'b0;

    always @(negedge clk) begin
        if (o_data[16]) begin
            m0_en++;
            if (!m0_pe) begin
                m0_gap = m0_low;
                m0_low = 0;
            end
            if (o_data[17] && !m0_pc) begin
                for (int k = 0; k < 16; k++) m0_sh[k] = {m0_sh[k][14:0], o_data[k]};
                m0_bits++;
            end
        end else begin
            m0_low++;
            if (m0_pe) begin
                m0_w = m0_sh;
                m0_lbits = m0_bits;
                m0_bits = 0;
                m0_len = m0_en;
                m0_en = 0;
                m0_frames++;
            end
        end
        m0_pc = o_data[17];
        m0_pe = o_data[16];
    end

    // Receiver for dut1.
    logic [15:0] m1_sh [16];
    logic [15:0] m1_w [16];
    int m1_bits = 0, m1_lbits = 0, m1_frames = 0;
    logic m1_pc = 1'b0, m1_pe = 1'b0;

    always @(negedge clk) begin
        if (q1[16]) begin
            if (q1[17] && !m1_pc) begin
                for (int k = 0; k < 16; k++) m1_sh[k] = {m1_sh[k][14:0], q1[k]};
                m1_bits++;
            end
        end else if (m1_pe) begin
            m1_w = m1_sh;
            m1_lbits = m1_bits;
            m1_bits = 0;
            m1_frames++;
        end
        m1_pc = q1[17];
        m1_pe = q1[16];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Pulse i_valid for one edge; returns at cycle N+1 (k=1).
    task automatic send(input logic [255:0] d);
        @(negedge clk);
        i_data  = d;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Counts cycles from k=1 until o_done, bounded.
    task automatic wait_done(inout int k);
        while (!o_done && k < 300) begin
            @(negedge clk);
            k++;
        end
    endtask

    int k, f0, dn;
    logic [255:0] d;
    logic [15:0] exp_w [16];

    initial begin
        // 1: reset held with i_valid high
        i_valid = 1'b1;
        i_data  = {16{16'hFFFF}};
        repeat (3) @(negedge clk);
        chk("rst_data", o_data, 18'h0);
        chk("rst_ready", o_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        i_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", o_busy, 0);
        chk("idle_data", o_data, 18'h0);

        // 2: single frame
        f0 = m0_frames;
        d = '0;
        d[15:0] = 16'hA5C3;
        d[255:240] = 16'h8001;
        send(d);
        k = 1;
        chk("f1_en", o_data[16], 1);
        chk("f1_sclk_lo", o_data[17], 0);
        chk("f1_lane0_msb", o_data[0], 1);
        chk("f1_lane15_msb", o_data[15], 1);
        chk("f1_ready", o_ready, 0);
        chk("f1_busy", o_busy, 1);
        @(negedge clk);
        @(negedge clk);
        k = 3;
        chk("f1_sclk_hi", o_data[17], 1);
        wait_done(k);
        chk("f1_done_at", k, 69);
        chk("f1_done_ready", o_ready, 1);
        chk("f1_done_busy", o_busy, 0);
        chk("f1_en_len", m0_len, 64);
        chk("f1_edges", m0_lbits, 16);
        chk("f1_lane0", m0_w[0], 16'hA5C3);
        chk("f1_lane15", m0_w[15], 16'h8001);
        chk("f1_lane7", m0_w[7], 16'h0);
        @(negedge clk);
        chk("f1_done_pulse", o_done, 0);
        chk("f1_frames", m0_frames - f0, 1);

        // 3: i_valid held high -> back-to-back frames
        repeat (5) @(negedge clk);
        f0 = m0_frames;
        d = '0;
        d[63:48] = 16'h1234;
        i_data = d;
        i_valid = 1'b1;
        k = 0;
        dn = 0;
        while (dn < 2 && k < 400) begin
            @(negedge clk);
            k++;
            if (o_done) dn++;
        end
        i_valid = 1'b0;
        // second done one full frame period after the first (69 + 69)
        chk("b2b_done_at", k, 138);
        // low stretch between frames: T gap cycles plus the done/idle cycle
        chk("b2b_gap", m0_gap, 5);
        repeat (10) @(negedge clk);
        chk("b2b_frames", m0_frames - f0, 2);
        chk("b2b_lane3", m0_w[3], 16'h1234);
        chk("b2b_idle", o_busy, 0);

        // 4: i_data change and i_valid pulse mid-frame
        f0 = m0_frames;
        d = '0;
        d[15:0] = 16'hA5C3;
        d[31:16] = 16'h1111;
        send(d);
        k = 1;
        repeat (19) @(negedge clk);
        k = 20;
        i_data = {16{16'hFFFF}};
        i_valid = 1'b1;
        @(negedge clk);
        k++;
        i_valid = 1'b0;
        chk("mid_ready", o_ready, 0);
        chk("mid_busy", o_busy, 1);
        wait_done(k);
        chk("mid_done_at", k, 69);
        chk("mid_lane0", m0_w[0], 16'hA5C3);
        chk("mid_lane1", m0_w[1], 16'h1111);
        repeat (80) @(negedge clk);
        chk("mid_frames", m0_frames - f0, 1);
        chk("mid_idle", o_busy, 0);

        // 5: reset at bit 7 (cycle N+29)
        d = '0;
        d[15:0] = 16'hFFFF;
        send(d);
        repeat (28) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_data", o_data, 18'h0);
        chk("abort_ready", o_ready, 1);
        chk("abort_busy", o_busy, 0);
        @(negedge clk);
        chk("abort_edges", m0_lbits, 7);
        d = '0;
        d[15:0] = 16'h5A5A;
        d[159:144] = 16'hC0DE;
        send(d);
        k = 1;
        wait_done(k);
        chk("clean_done_at", k, 69);
        chk("clean_en_len", m0_len, 64);
        chk("clean_edges", m0_lbits, 16);
        chk("clean_lane0", m0_w[0], 16'h5A5A);
        chk("clean_lane9", m0_w[9], 16'hC0DE);

        // 6: loopback at CLK_DIV=1 with random words
        f0 = m1_frames;
        for (int fr = 0; fr < 100; fr++) begin
            @(negedge clk);
            for (int w = 0; w < 16; w++) begin
                exp_w[w] = 16'($urandom);
                d1[w*16 +: 16] = exp_w[w];
            end
            v1 = 1'b1;
            @(negedge clk);
            v1 = 1'b0;
            k = 1;
            while (!n1 && k < 100) begin
                @(negedge clk);
                k++;
            end
            if (fr == 0) chk("lb_done_at", k, 35);
            chk("lb_edges", m1_lbits, 16);
            for (int w = 0; w < 16; w++) chk("lb_word", m1_w[w], exp_w[w]);
        end
        @(negedge clk);
        chk("lb_frames", m1_frames - f0, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
